dmem_arbiter: RTL and testbench

Shares the single-port synchronous data RAM (RAMMemory: 1-cycle read latency, address/data/wren registered on clk) between the ARM core's data port and one auxiliary master (DMA/video/debug reader).
- Sits between `arm` and `RAMMemory` in `top`.
- The CPU has fixed priority. The aux master has a starvation guard.
- Read data is returned with a per-requester valid strobe.

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arb_starve_ctr.sv | 30 +++
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-RAM arbiter: read-return owner encoding and starve counter width.
// Pure declarations; no timing or flow control of its own.
package dmem_arb_pkg;

  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_AUX  = 2'd2
  } owner_t;

  // Next read-return owner from this cycle's grants (grants are mutually exclusive).
  function automatic owner_t next_owner(input logic cpu_rd_gnt, input logic aux_rd_gnt);
    owner_t o;
    o = OWN_NONE;
    if (cpu_rd_gnt)      o = OWN_CPU;
    else if (aux_rd_gnt) o = OWN_AUX;
    return o;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and RAM-side signal bundle for dmem_arbiter; slave = arbiter view, master = requesters/RAM view.
// Grants are same-cycle, read data follows one cycle after a read grant.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  import dmem_arb_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              aux_req;
  logic              aux_we;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_wdata;
  logic              aux_gnt;
  logic              aux_rvalid;
  logic [DATA_W-1:0] aux_rdata;

  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    input  ram_q,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output aux_gnt, aux_rvalid, aux_rdata,
    output ram_address, ram_data, ram_wren
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output aux_req, aux_we, aux_addr, aux_wdata,
    output ram_q,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  aux_gnt, aux_rvalid, aux_rdata,
    input  ram_address, ram_data, ram_wren
  );

endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of cycles a requester waits (req=1, gnt=0); optionally cleared by a grant or an idle cycle.
// Count visible the cycle after the wait; no backpressure, it only observes req/gnt.
module dmem_arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int           W          = STARVE_W,
  parameter logic [W-1:0] LIMIT      = '1,
  parameter bit           CLR_ON_GNT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  input  logic         gnt,
  output logic [W-1:0] cnt,
  output logic         at_limit
);

  always_comb at_limit = (cnt == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (CLR_ON_GNT && (gnt || !req)) begin
      cnt <= '0;
    end else if (req && !gnt && !at_limit) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/aux arbiter for the single-port data RAM: same-cycle grant, read data 1 cycle after a read grant.
// CPU has fixed priority; aux wins after MAX_WAIT denied cycles. Optional wait counters: DMEM_ARB_PERF_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  dmem_arbiter_if.slave       bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]         cpu_wait_cnt,
  output logic [31:0]         aux_wait_cnt
`endif
);

  logic                cpu_gnt_i;
  logic                aux_gnt_i;
  logic                aux_win;
  logic                starve_at_limit;
  logic [STARVE_W-1:0] starve_cnt;
  logic [ADDR_W-1:0]   addr_mux;
  logic [DATA_W-1:0]   data_mux;
  owner_t              owner_q;
  owner_t              owner_d;

  dmem_arb_starve_ctr #(
    .W          (STARVE_W),
    .LIMIT      (STARVE_W'(MAX_WAIT)),
    .CLR_ON_GNT (1'b1)
  ) u_starve (
    .clk      (clk),
    .rst      (reset),
    .req      (bus.aux_req),
    .gnt      (aux_gnt_i),
    .cnt      (starve_cnt),
    .at_limit (starve_at_limit)
  );

  // Grants are forced low while reset is asserted, independent of the clock.
  always_comb begin
    aux_win   = bus.aux_req && (!bus.cpu_req || starve_at_limit);
    aux_gnt_i = !reset && aux_win;
    cpu_gnt_i = !reset && bus.cpu_req && !aux_win;
  end

  always_comb begin
    addr_mux = bus.cpu_addr;
    data_mux = bus.cpu_wdata;
    if (aux_gnt_i) begin
      addr_mux = bus.aux_addr;
      data_mux = bus.aux_wdata;
    end
  end

  always_comb begin
    bus.cpu_gnt     = cpu_gnt_i;
    bus.aux_gnt     = aux_gnt_i;
    bus.ram_address = addr_mux;
    bus.ram_data    = data_mux;
    bus.ram_wren    = (cpu_gnt_i && bus.cpu_we) || (aux_gnt_i && bus.aux_we);
  end

  // Read-return owner: which requester receives ram_q in the cycle after its read grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) owner_q <= OWN_NONE;
    else       owner_q <= owner_d;
  end

  always_comb begin
    owner_d        = OWN_NONE;
    bus.cpu_rvalid = 1'b0;
    bus.aux_rvalid = 1'b0;
    bus.cpu_rdata  = bus.ram_q;
    bus.aux_rdata  = bus.ram_q;
    owner_d        = next_owner(cpu_gnt_i && !bus.cpu_we, aux_gnt_i && !bus.aux_we);
    if (!reset) begin
      bus.cpu_rvalid = (owner_q == OWN_CPU);
      bus.aux_rvalid = (owner_q == OWN_AUX);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (starve_cnt <= STARVE_W'(MAX_WAIT));
  end

`ifdef DMEM_ARB_PERF_EN
  logic cpu_wait_sat;
  logic aux_wait_sat;

  dmem_arb_starve_ctr #(
    .W          (32),
    .LIMIT      (32'hFFFF_FFFF),
    .CLR_ON_GNT (1'b0)
  ) u_cpu_wait (
    .clk      (clk),
    .rst      (reset),
    .req      (bus.cpu_req),
    .gnt      (cpu_gnt_i),
    .cnt      (cpu_wait_cnt),
    .at_limit (cpu_wait_sat)
  );

  dmem_arb_starve_ctr #(
    .W          (32),
    .LIMIT      (32'hFFFF_FFFF),
    .CLR_ON_GNT (1'b0)
  ) u_aux_wait (
    .clk      (clk),
    .rst      (reset),
    .req      (bus.aux_req),
    .gnt      (aux_gnt_i),
    .cnt      (aux_wait_cnt),
    .at_limit (aux_wait_sat)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed requests with a small 1-cycle RAM model and an rvalid scoreboard.
module tb_dmem_arbiter;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [31:0] exp_cpu_q[$];
  logic [31:0] exp_aux_q[$];
  logic        prev_cpu_rd = 1'b0;
  logic        prev_aux_rd = 1'b0;
  int          cpu_rv_cyc = -1;
  int          aux_rv_cyc = -1;
  logic [31:0] mem [0:255];

  dmem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] cpu_wait_cnt;
  logic [31:0] aux_wait_cnt;
`endif

  dmem_arbiter #(
    .ADDR_W   (16),
    .DATA_W   (32),
    .MAX_WAIT (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus)
`ifdef DMEM_ARB_PERF_EN
    ,
    .cpu_wait_cnt (cpu_wait_cnt),
    .aux_wait_cnt (aux_wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM: address/data/wren registered, q valid the cycle after.
  always @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_address[7:0]] <= bus.ram_data;
    bus.ram_q <= mem[bus.ram_address[7:0]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops an expected word whenever an rvalid appears.
  always @(negedge clk) begin
    if (reset) begin
      check("reset_quiet", {59'd0, bus.cpu_gnt, bus.aux_gnt, bus.ram_wren, bus.cpu_rvalid, bus.aux_rvalid}, 64'd0);
      prev_cpu_rd = 1'b0;
      prev_aux_rd = 1'b0;
    end else begin
      check("single_gnt", {63'd0, bus.cpu_gnt && bus.aux_gnt}, 64'd0);
      if (bus.cpu_rvalid) begin
        check("cpu_rvalid_latency", {63'd0, prev_cpu_rd}, 64'd1);
        cpu_rv_cyc = cyc;
        if (exp_cpu_q.size() == 0) check("cpu_rvalid_unexpected", 64'd1, 64'd0);
        else check("cpu_rdata", {32'd0, bus.cpu_rdata}, {32'd0, exp_cpu_q.pop_front()});
      end
      if (bus.aux_rvalid) begin
        check("aux_rvalid_latency", {63'd0, prev_aux_rd}, 64'd1);
        aux_rv_cyc = cyc;
        if (exp_aux_q.size() == 0) check("aux_rvalid_unexpected", 64'd1, 64'd0);
        else check("aux_rdata", {32'd0, bus.aux_rdata}, {32'd0, exp_aux_q.pop_front()});
      end
      prev_cpu_rd = bus.cpu_gnt && !bus.cpu_we;
      prev_aux_rd = bus.aux_gnt && !bus.aux_we;
    end
  end

  task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp, output int gcyc);
    bit got;
    got  = 1'b0;
    gcyc = -1;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    if (!we) exp_cpu_q.push_back(exp);
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (bus.cpu_gnt) begin got = 1'b1; gcyc = cyc; end
    end
    if (!got) check("cpu_gnt_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
  endtask

  task automatic aux_access(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp, output int gcyc);
    bit got;
    got  = 1'b0;
    gcyc = -1;
    bus.aux_req = 1'b1; bus.aux_we = we; bus.aux_addr = addr; bus.aux_wdata = wdata;
    if (!we) exp_aux_q.push_back(exp);
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (bus.aux_gnt) begin got = 1'b1; gcyc = cyc; end
    end
    if (!got) check("aux_gnt_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.aux_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gc, ga;
    bit aux_exp;
    reset = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.aux_req = 1'b0; bus.aux_we = 1'b0; bus.aux_addr = '0; bus.aux_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Reset lands the cycle after a read grant: the rvalid must never appear.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
    @(negedge clk);
    check("midread_gnt", {63'd0, bus.cpu_gnt}, 64'd1);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midread_no_rvalid", {63'd0, bus.cpu_rvalid}, 64'd0);
    @(posedge clk); #1 bus.cpu_req = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // CPU write then read of the same word.
    cpu_access(1'b1, 16'h0010, 32'hDEADBEEF, 32'h0, gc);
    cpu_access(1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, ga);
    check("wr_rd_consecutive_gnt", ga, gc + 1);
    repeat (2) @(posedge clk);
    #1;
    check("cpu_rvalid_cycle", cpu_rv_cyc, ga + 1);

    // Simultaneous reads: CPU first, aux next, rvalids back to back.
    cpu_access(1'b1, 16'h0004, 32'h00000011, 32'h0, gc);
    cpu_access(1'b1, 16'h0008, 32'h00000022, 32'h0, gc);
    fork
      cpu_access(1'b0, 16'h0004, 32'h0, 32'h00000011, gc);
      aux_access(1'b0, 16'h0008, 32'h0, 32'h00000022, ga);
    join
    check("both_rd_aux_after_cpu", ga, gc + 1);
    repeat (2) @(posedge clk);
    #1;
    check("both_rd_cpu_rv", cpu_rv_cyc, gc + 1);
    check("both_rd_aux_rv", aux_rv_cyc, ga + 1);

    // Aux write then CPU read of the same word.
    aux_access(1'b1, 16'h0020, 32'hCAFEF00D, 32'h0, ga);
    cpu_access(1'b0, 16'h0020, 32'h0, 32'hCAFEF00D, gc);
    check("aux_wr_cpu_rd_gnt", gc, ga + 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // Both requesters held for 20 cycles: aux wins on every 5th cycle.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0030; bus.cpu_wdata = 32'h1;
    bus.aux_req = 1'b1; bus.aux_we = 1'b1; bus.aux_addr = 16'h0031; bus.aux_wdata = 32'h2;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      aux_exp = (i % 5 == 0);
      check($sformatf("hold_aux_gnt_c%0d", i), {63'd0, bus.aux_gnt}, {63'd0, aux_exp});
      check($sformatf("hold_cpu_gnt_c%0d", i), {63'd0, bus.cpu_gnt}, {63'd0, !aux_exp});
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0; bus.aux_req = 1'b0;
    @(negedge clk);
`ifdef DMEM_ARB_PERF_EN
    check("perf_aux_wait", {32'd0, aux_wait_cnt}, 64'd16);
    check("perf_cpu_wait", {32'd0, cpu_wait_cnt}, 64'd4);
`endif

    repeat (3) @(negedge clk);
    check("cpu_queue_drained", exp_cpu_q.size(), 64'd0);
    check("aux_queue_drained", exp_aux_q.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
